// File: rtl/outr_pkg.sv
// -----------------------------------------------------------------------------
// outr_pkg
// Shared definitions for the OUTR serial transmitter: FSM state encoding and
// the idle level of the serial line.
// -----------------------------------------------------------------------------
package outr_pkg;

    // Transmit FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } outr_state_e;

    // Level the serial line rests at between frames (mark)
    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage : outr_pkg

// File: rtl/outr_baud_counter.sv
// -----------------------------------------------------------------------------
// outr_baud_counter
// Counts clk cycles within one serial bit period. Counts 0..CLKS_PER_BIT-1,
// wraps to 0 and flags bit_done during the terminal count cycle.
// Ports:
//   clk          system clock
//   reset_outr_n asynchronous active-low reset
//   clear        holds the counter at 0 (asserted while no frame is running)
//   bit_done     high in the last cycle of each bit period
// -----------------------------------------------------------------------------
module outr_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_outr_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Terminal-count tick; suppressed while held in clear
    assign bit_done = (~clear) & (cnt_r == TERM);

    // Baud counter: clear, wrap at terminal count, otherwise increment
    always_ff @(posedge clk or negedge reset_outr_n) begin
        if (!reset_outr_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == TERM) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule : outr_baud_counter

// File: rtl/outr_serial_tx.sv
// -----------------------------------------------------------------------------
// outr_serial_tx
// Output register (OUTR) and serial transmitter of the basic computer. An OUT
// instruction loads OUTR and clears FGO; the character is then sent as one
// start bit, WIDTH data bits LSB first and one stop bit. FGO returns to 1 on
// the edge that ends the stop bit.
// Ports:
//   clk          system clock
//   reset_outr_n asynchronous active-low reset
//   write_outr   OUT strobe (single cycle), accepted only while fgo=1
//   DATA_outr    character to load (AC low bits)
//   ien          interrupt enable
//   op_of_outr   current OUTR contents (kept after the frame is sent)
//   fgo          output flag, 1 = ready for a new character
//   irq_out      ien & fgo
//   tx           registered serial line, idles high
//   busy         ~fgo
// -----------------------------------------------------------------------------
module outr_serial_tx
    import outr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset_outr_n,
    input  logic             write_outr,
    input  logic [WIDTH-1:0] DATA_outr,
    input  logic             ien,
    output logic [WIDTH-1:0] op_of_outr,
    output logic             fgo,
    output logic             irq_out,
    output logic             tx,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    outr_state_e      state_r, state_next_s;
    logic [WIDTH-1:0] outr_r, outr_next_s;
    logic [IW-1:0]    idx_r, idx_next_s, idx_inc_s;
    logic             fgo_r, fgo_next_s;
    logic             tx_r, tx_next_s;
    logic             bit_done_s;
    logic             baud_clear_s;

    // Baud timing only runs while a frame is in flight
    assign baud_clear_s = (state_r == IDLE);

    outr_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk          (clk),
        .reset_outr_n (reset_outr_n),
        .clear        (baud_clear_s),
        .bit_done     (bit_done_s)
    );

    assign idx_inc_s = idx_r + {{(IW-1){1'b0}}, 1'b1};

    // Next-state logic; tx_next is the level of the period being entered so
    // the registered tx changes on the same edge as the state
    always_comb begin
        state_next_s = state_r;
        outr_next_s  = outr_r;
        idx_next_s   = idx_r;
        fgo_next_s   = fgo_r;
        tx_next_s    = tx_r;
        case (state_r)
            IDLE: begin
                if (write_outr && fgo_r) begin
                    outr_next_s  = DATA_outr;
                    fgo_next_s   = 1'b0;
                    state_next_s = START;
                    tx_next_s    = 1'b0;
                end else begin
                    tx_next_s    = TX_IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_next_s = DATA;
                    idx_next_s   = {IW{1'b0}};
                    tx_next_s    = outr_r[0];
                end else begin
                    tx_next_s    = 1'b0;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_next_s = STOP;
                        tx_next_s    = TX_IDLE_LEVEL;
                    end else begin
                        idx_next_s   = idx_inc_s;
                        tx_next_s    = outr_r[idx_inc_s];
                    end
                end else begin
                    tx_next_s = outr_r[idx_r];
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    state_next_s = IDLE;
                    fgo_next_s   = 1'b1;
                end else begin
                    fgo_next_s   = 1'b0;
                end
                tx_next_s = TX_IDLE_LEVEL;
            end
            default: begin
                state_next_s = IDLE;
                fgo_next_s   = 1'b1;
                tx_next_s    = TX_IDLE_LEVEL;
            end
        endcase
    end

    // State, OUTR, flag, bit index and line registers
    always_ff @(posedge clk or negedge reset_outr_n) begin
        if (!reset_outr_n) begin
            state_r <= IDLE;
            outr_r  <= {WIDTH{1'b0}};
            idx_r   <= {IW{1'b0}};
            fgo_r   <= 1'b1;
            tx_r    <= TX_IDLE_LEVEL;
        end else begin
            state_r <= state_next_s;
            outr_r  <= outr_next_s;
            idx_r   <= idx_next_s;
            fgo_r   <= fgo_next_s;
            tx_r    <= tx_next_s;
        end
    end

    assign op_of_outr = outr_r;
    assign fgo        = fgo_r;
    assign tx         = tx_r;
    assign busy       = ~fgo_r;
    assign irq_out    = ien & fgo_r;

endmodule : outr_serial_tx

// File: tb/tb_outr_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_outr_serial_tx
// Self-checking bench for outr_serial_tx (WIDTH=8, CLKS_PER_BIT=4). Accepted
// characters are pushed to a scoreboard; a line monitor rebuilds each frame
// from tx and compares it with the oldest expected character.
// -----------------------------------------------------------------------------
module tb_outr_serial_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int FRAME_CYCLES = (W + 2) * CPB;

    logic         clk;
    logic         reset_outr_n;
    logic         write_outr;
    logic [W-1:0] DATA_outr;
    logic         ien;
    logic [W-1:0] op_of_outr;
    logic         fgo;
    logic         irq_out;
    logic         tx;
    logic         busy;

    int n_checks;
    int n_fail;
    int frames;

    logic [W-1:0] sb[$];

    outr_serial_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .reset_outr_n (reset_outr_n),
        .write_outr   (write_outr),
        .DATA_outr    (DATA_outr),
        .ien          (ien),
        .op_of_outr   (op_of_outr),
        .fgo          (fgo),
        .irq_out      (irq_out),
        .tx           (tx),
        .busy         (busy)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line monitor: rebuild a frame from tx, sampled on the falling clock edge
    int              m_c;
    logic            m_act;
    logic [W+1:0]    m_bits;
    logic            m_glitch;
    logic [W-1:0]    m_exp;
    initial begin
        m_act = 1'b0;
        frames = 0;
    end
    always @(negedge clk) begin
        if (!reset_outr_n) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx == 1'b0) begin
                m_act    = 1'b1;
                m_c      = 0;
                m_bits   = '0;
                m_glitch = 1'b0;
            end
        end else begin
            m_c = m_c + 1;
            if ((m_c % CPB) == 0) begin
                m_bits[m_c / CPB] = tx;
            end else if (tx !== m_bits[m_c / CPB]) begin
                m_glitch = 1'b1;
            end
            if (m_c == FRAME_CYCLES - 1) begin
                m_act = 1'b0;
                frames++;
                m_exp = 'x;
                if (sb.size() > 0) m_exp = sb.pop_front();
                check_eq("start_bit", 32'(m_bits[0]), 32'd0);
                check_eq("stop_bit", 32'(m_bits[W+1]), 32'd1);
                check_eq("bit_stable", 32'(m_glitch), 32'd0);
                check_eq("frame_data", 32'(m_bits[W:1]), 32'(m_exp));
            end
        end
    end

    // One-cycle OUT strobe; returns on the falling edge after the sampling edge
    task automatic do_write(input logic [W-1:0] d);
        @(negedge clk);
        write_outr = 1'b1;
        DATA_outr  = d;
        @(negedge clk);
        write_outr = 1'b0;
    endtask

    // Count falling edges with fgo low until it rises (bounded)
    task automatic wait_idle(output int n, output logic irq_seen);
        n = 0;
        irq_seen = 1'b0;
        while (fgo == 1'b0 && n < 1000) begin
            if (irq_out) irq_seen = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    int   n_low;
    logic irq_seen;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_outr_n = 1'b0;
        write_outr   = 1'b0;
        DATA_outr    = '0;
        ien          = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_op", 32'(op_of_outr), 32'h0);
        check_eq("rst_fgo", 32'(fgo), 32'd1);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_irq", 32'(irq_out), 32'd1);
        reset_outr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x41
        sb.push_back(8'h41);
        do_write(8'h41);
        check_eq("f1_tx_fall", 32'(tx), 32'd0);
        check_eq("f1_busy", 32'(busy), 32'd1);
        check_eq("f1_irq_low", 32'(irq_out), 32'd0);
        wait_idle(n_low, irq_seen);
        check_eq("f1_fgo_low_cycles", 32'(n_low), 32'(FRAME_CYCLES));
        check_eq("f1_irq_in_frame", 32'(irq_seen), 32'd0);
        check_eq("f1_irq_end", 32'(irq_out), 32'd1);
        check_eq("f1_tx_idle", 32'(tx), 32'd1);
        check_eq("f1_op", 32'(op_of_outr), 32'h41);
        repeat (3) @(negedge clk);

        // Write while busy: second character ignored
        sb.push_back(8'h55);
        do_write(8'h55);
        repeat (8) @(negedge clk);
        do_write(8'hAA);
        check_eq("busy_op_kept", 32'(op_of_outr), 32'h55);
        wait_idle(n_low, irq_seen);
        check_eq("busy_frame_len", 32'(n_low), 32'(FRAME_CYCLES - 10));
        check_eq("busy_op_after", 32'(op_of_outr), 32'h55);
        repeat (3) @(negedge clk);

        // Boundary: write on the fgo-rise edge dropped, one cycle later accepted
        sb.push_back(8'h3C);
        do_write(8'h3C);
        repeat (FRAME_CYCLES - 1) @(negedge clk);
        check_eq("bnd_still_busy", 32'(fgo), 32'd0);
        write_outr = 1'b1;
        DATA_outr  = 8'hC3;
        @(negedge clk);
        check_eq("bnd_fgo_rise", 32'(fgo), 32'd1);
        check_eq("bnd_idle_cycle", 32'(tx), 32'd1);
        check_eq("bnd_drop_op", 32'(op_of_outr), 32'h3C);
        sb.push_back(8'h5A);
        DATA_outr  = 8'h5A;
        @(negedge clk);
        write_outr = 1'b0;
        check_eq("bnd_accept_tx", 32'(tx), 32'd0);
        check_eq("bnd_accept_fgo", 32'(fgo), 32'd0);
        wait_idle(n_low, irq_seen);
        check_eq("bnd_frame_len", 32'(n_low), 32'(FRAME_CYCLES));
        check_eq("bnd_op", 32'(op_of_outr), 32'h5A);
        repeat (3) @(negedge clk);

        // Reset 13 cycles into a frame of 0xFF, then a clean 0x00 frame
        sb.push_back(8'hFF);
        do_write(8'hFF);
        repeat (12) @(negedge clk);
        reset_outr_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx), 32'd1);
        check_eq("mid_rst_fgo", 32'(fgo), 32'd1);
        check_eq("mid_rst_op", 32'(op_of_outr), 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_outr_n = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back(8'h00);
        do_write(8'h00);
        wait_idle(n_low, irq_seen);
        check_eq("post_rst_len", 32'(n_low), 32'(FRAME_CYCLES));
        check_eq("post_rst_op", 32'(op_of_outr), 32'h00);
        repeat (3) @(negedge clk);

        // Interrupts disabled: irq_out never rises
        ien = 1'b0;
        @(negedge clk);
        check_eq("ien0_idle_irq", 32'(irq_out), 32'd0);
        sb.push_back(8'h96);
        do_write(8'h96);
        wait_idle(n_low, irq_seen);
        repeat (3) @(negedge clk);
        if (irq_out) irq_seen = 1'b1;
        check_eq("ien0_irq", 32'(irq_seen), 32'd0);
        check_eq("ien0_op", 32'(op_of_outr), 32'h96);

        // Every expected character must have been framed exactly once
        repeat (5) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        check_eq("frame_count", 32'(frames), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_outr_serial_tx
